escalonador_paradas: RTL and testbench

SCAN-based stop scheduler and car sequencer for the elevator. It accepts origin/destination call pairs and holds them as pending-stop bitmaps, so there is no queue and no overflow. It advances the car one floor per travel interval and holds the doors open at each served floor. It sits between the user request path and the car-position/door datapath, and replaces FIFO-order stop service with direction-ordered service.

---
 rtl/elevador_pkg.sv | 11 +
 rtl/seletor_parada.sv | 36 +++
 rtl/escalonador_paradas.sv | 173 +++++++++++++++++
 tb/tb_escalonador_paradas.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/elevador_pkg.sv
// Shared types and default sizing for the elevator stop scheduler.
package elevador_pkg;
  localparam int N_ANDARES = 16;
  localparam int LARGURA   = 4;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    MOVENDO = 2'd1,
    PORTA   = 2'd2
  } estado_t;
endpackage

// File: rtl/seletor_parada.sv
// Combinational search of the pending-stop bitmap around the current floor:
// reports whether stops exist strictly above/below and the nearest one each way.
module seletor_parada #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] pendentes,
  input  logic [W-1:0] andar,
  output logic         ha_acima,
  output logic         ha_abaixo,
  output logic [W-1:0] proxAcima,
  output logic [W-1:0] proxAbaixo
);
  logic [N-1:0] acimaBits;
  logic [N-1:0] abaixoBits;

  for (genvar gi = 0; gi < N; gi++) begin : gMascara
    assign acimaBits[gi]  = pendentes[gi] && (W'(gi) > andar);
    assign abaixoBits[gi] = pendentes[gi] && (W'(gi) < andar);
  end

  assign ha_acima  = |acimaBits;
  assign ha_abaixo = |abaixoBits;

  // Nearest stops include the current floor itself.
  always_comb begin
    proxAcima  = andar;
    proxAbaixo = andar;
    for (int i = N - 1; i >= 0; i--) begin
      if (pendentes[i] && (W'(i) >= andar)) proxAcima = W'(i);
    end
    for (int i = 0; i < N; i++) begin
      if (pendentes[i] && (W'(i) <= andar)) proxAbaixo = W'(i);
    end
  end
endmodule

// File: rtl/escalonador_paradas.sv
// SCAN stop scheduler: keeps hall/cabin stops as bitmaps, moves the car one
// floor per travel interval and holds the door at each served floor.
module escalonador_paradas
  import elevador_pkg::*;
#(
  parameter int N_ANDARES = elevador_pkg::N_ANDARES,
  parameter int LARGURA   = elevador_pkg::LARGURA,
  parameter int T_ANDAR   = 100,
  parameter int T_PORTA   = 200
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               novaEntrada,
  input  logic [LARGURA-1:0] origem,
  input  logic [LARGURA-1:0] destino,
  output logic [LARGURA-1:0] andarAtual,
  output logic [LARGURA-1:0] proxParada,
  output logic               paradaValida,
  output logic               elevador_subindo,
  output logic               movendo,
  output logic               portaAberta,
  output logic               erroEntrada,
  output logic [1:0]         dbEstado
);
  localparam int TMAX = (T_PORTA > T_ANDAR) ? T_PORTA : T_ANDAR;
  localparam int TW   = $clog2(TMAX + 1);

  estado_t                state, stateNext;
  logic [TW-1:0]          timer, timerNext;
  logic [LARGURA-1:0]     andarNext;
  logic                   subindoNext;
  logic                   entraPorta;
  logic [N_ANDARES-1:0]   pedidoOrigem, pedidoNext;
  logic [N_ANDARES-1:0]   paradas, paradasNext;
  logic [N_ANDARES-1:0]   destinoPendente [N_ANDARES];
  logic [N_ANDARES-1:0]   destinoNext [N_ANDARES];
  logic [N_ANDARES-1:0]   pend;
  logic                   haAcima, haAbaixo;
  logic [LARGURA-1:0]     proxAcima, proxAbaixo;
  logic                   valida, reinicia;

  assign pend = pedidoOrigem | paradas;
  assign valida = (int'(origem) < N_ANDARES) && (int'(destino) < N_ANDARES) && (origem != destino);
  // A call from the floor whose door is open boards immediately.
  assign reinicia = (state == PORTA) && novaEntrada && valida && (origem == andarAtual);

  seletor_parada #(.N(N_ANDARES), .W(LARGURA)) uSeletor (
    .pendentes (pend),
    .andar     (andarAtual),
    .ha_acima  (haAcima),
    .ha_abaixo (haAbaixo),
    .proxAcima (proxAcima),
    .proxAbaixo(proxAbaixo)
  );

  always_comb begin
    proxParada = andarAtual;
    if (elevador_subindo) begin
      if (pend[andarAtual] || haAcima) proxParada = proxAcima;
      else if (haAbaixo)               proxParada = proxAbaixo;
    end else begin
      if (pend[andarAtual] || haAbaixo) proxParada = proxAbaixo;
      else if (haAcima)                 proxParada = proxAcima;
    end
  end

  assign paradaValida = |pend;
  assign movendo      = (state == MOVENDO);
  assign portaAberta  = (state == PORTA);
  assign dbEstado     = state;

  always_comb begin
    stateNext   = state;
    timerNext   = timer;
    andarNext   = andarAtual;
    subindoNext = elevador_subindo;
    entraPorta  = 1'b0;
    case (state)
      OCIOSO: begin
        if (pend[andarAtual]) begin
          stateNext  = PORTA;
          entraPorta = 1'b1;
          timerNext  = TW'(T_PORTA - 1);
        end else if (elevador_subindo ? haAcima : haAbaixo) begin
          stateNext = MOVENDO;
          timerNext = TW'(T_ANDAR - 1);
        end else if (elevador_subindo ? haAbaixo : haAcima) begin
          stateNext   = MOVENDO;
          subindoNext = !elevador_subindo;
          timerNext   = TW'(T_ANDAR - 1);
        end
      end
      MOVENDO: begin
        if (timer != '0) begin
          timerNext = timer - TW'(1);
        end else begin
          andarNext = elevador_subindo ? andarAtual + LARGURA'(1) : andarAtual - LARGURA'(1);
          if (pend[andarNext]) begin
            stateNext  = PORTA;
            entraPorta = 1'b1;
            timerNext  = TW'(T_PORTA - 1);
          end else begin
            timerNext = TW'(T_ANDAR - 1);
          end
        end
      end
      PORTA: begin
        if (reinicia) begin
          timerNext = TW'(T_PORTA - 1);
        end else if (timer != '0) begin
          timerNext = timer - TW'(1);
        end else if (elevador_subindo ? haAcima : haAbaixo) begin
          stateNext = MOVENDO;
          timerNext = TW'(T_ANDAR - 1);
        end else if (elevador_subindo ? haAbaixo : haAcima) begin
          stateNext   = MOVENDO;
          subindoNext = !elevador_subindo;
          timerNext   = TW'(T_ANDAR - 1);
        end else begin
          stateNext = OCIOSO;
        end
      end
      default: stateNext = OCIOSO;
    endcase
  end

  // Stop service is applied before new requests so a same-edge request survives.
  always_comb begin
    pedidoNext  = pedidoOrigem;
    paradasNext = paradas;
    destinoNext = destinoPendente;
    if (entraPorta) begin
      pedidoNext[andarNext]  = 1'b0;
      paradasNext[andarNext] = 1'b0;
      paradasNext            = paradasNext | destinoPendente[andarNext];
      destinoNext[andarNext] = '0;
    end
    if (novaEntrada && valida) begin
      if (reinicia) begin
        paradasNext[destino] = 1'b1;
      end else begin
        pedidoNext[origem]          = 1'b1;
        destinoNext[origem][destino] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= OCIOSO;
      timer            <= '0;
      andarAtual       <= '0;
      elevador_subindo <= 1'b1;
      erroEntrada      <= 1'b0;
      pedidoOrigem     <= '0;
      paradas          <= '0;
      for (int i = 0; i < N_ANDARES; i++) destinoPendente[i] <= '0;
    end else begin
      state            <= stateNext;
      timer            <= timerNext;
      andarAtual       <= andarNext;
      elevador_subindo <= subindoNext;
      erroEntrada      <= novaEntrada && !valida;
      pedidoOrigem     <= pedidoNext;
      paradas          <= paradasNext;
      destinoPendente  <= destinoNext;
    end
  end

  aStepInRange: assert property (@(posedge clock) disable iff (!reset)
    (state == MOVENDO && timer == '0) |->
      (elevador_subindo ? (andarAtual != LARGURA'(N_ANDARES - 1)) : (andarAtual != '0)));
endmodule

// File: tb/tb_escalonador_paradas.sv
// Directed bench for escalonador_paradas; served stops are checked against a scoreboard.
module tb_escalonador_paradas;
  localparam int TA = 4;
  localparam int TP = 6;

  logic       clock = 1'b0;
  logic       reset;
  logic       novaEntrada;
  logic [3:0] origem, destino;
  logic [3:0] andarAtual, proxParada;
  logic       paradaValida, elevador_subindo, movendo, portaAberta, erroEntrada;
  logic [1:0] dbEstado;

  typedef struct {int andar; int sub;} parada_t;
  parada_t expQ[$];
  int checks = 0;
  int errors = 0;
  logic prevPorta = 1'b0;

  always #5 clock = ~clock;

  escalonador_paradas #(.T_ANDAR(TA), .T_PORTA(TP)) dut (
    .clock           (clock),
    .reset           (reset),
    .novaEntrada     (novaEntrada),
    .origem          (origem),
    .destino         (destino),
    .andarAtual      (andarAtual),
    .proxParada      (proxParada),
    .paradaValida    (paradaValida),
    .elevador_subindo(elevador_subindo),
    .movendo         (movendo),
    .portaAberta     (portaAberta),
    .erroEntrada     (erroEntrada),
    .dbEstado        (dbEstado)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic advance(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse(input int o, input int d);
    @(negedge clock);
    novaEntrada = 1'b1;
    origem      = 4'(o);
    destino     = 4'(d);
    @(posedge clock);
    #1;
    novaEntrada = 1'b0;
    $display("request %0d -> %0d", o, d);
  endtask

  task automatic waitMove();
    for (int i = 0; i < 100 && !movendo; i++) advance(1);
    chk("wait movendo", 32'(movendo), 32'd1);
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 2000 && !(dbEstado == 2'd0 && !paradaValida); i++) advance(1);
    chk(tag, 32'(dbEstado == 2'd0 && !paradaValida), 32'd1);
    chk("all stops served", 32'(expQ.size()), 32'd0);
  endtask

  task automatic chkReset(input string tag);
    chk({tag, " andarAtual"}, 32'(andarAtual), 32'd0);
    chk({tag, " proxParada"}, 32'(proxParada), 32'd0);
    chk({tag, " paradaValida"}, 32'(paradaValida), 32'd0);
    chk({tag, " subindo"}, 32'(elevador_subindo), 32'd1);
    chk({tag, " movendo"}, 32'(movendo), 32'd0);
    chk({tag, " portaAberta"}, 32'(portaAberta), 32'd0);
    chk({tag, " erroEntrada"}, 32'(erroEntrada), 32'd0);
    chk({tag, " dbEstado"}, 32'(dbEstado), 32'd0);
  endtask

  // Each door opening consumes the next expected stop.
  always @(negedge clock) begin
    if (reset === 1'b1 && portaAberta && !prevPorta) begin
      if (expQ.size() == 0) begin
        chk("unexpected stop", 32'(expQ.size()), 32'd1);
      end else begin
        parada_t e;
        e = expQ.pop_front();
        $display("stop at floor %0d subindo=%0d", andarAtual, elevador_subindo);
        chk("stop floor", 32'(andarAtual), 32'(e.andar));
        chk("stop dir", 32'(elevador_subindo), 32'(e.sub));
      end
    end
    prevPorta <= portaAberta;
  end

  initial begin
    reset = 1'b0; novaEntrada = 1'b0; origem = '0; destino = '0;
    #12;
    chkReset("reset");
    @(negedge clock); reset = 1'b1;
    advance(2);

    // 0->3 with exact timing
    expQ.push_back('{0, 1});
    expQ.push_back('{3, 1});
    pulse(0, 3);
    chk("t1 still idle", 32'(dbEstado), 32'd0);
    chk("t1 S visible", 32'(paradaValida), 32'd1);
    chk("t1 proxParada", 32'(proxParada), 32'd0);
    advance(1);
    chk("t1 porta k+1", 32'(portaAberta), 32'd1);
    advance(5);
    chk("t1 porta k+6", 32'(portaAberta), 32'd1);
    advance(1);
    chk("t1 movendo k+7", 32'(movendo), 32'd1);
    advance(3);
    chk("t1 andar k+10", 32'(andarAtual), 32'd0);
    advance(1);
    chk("t1 andar k+11", 32'(andarAtual), 32'd1);
    advance(8);
    chk("t1 andar k+19", 32'(andarAtual), 32'd3);
    chk("t1 porta k+19", 32'(portaAberta), 32'd1);
    advance(5);
    chk("t1 porta k+24", 32'(portaAberta), 32'd1);
    advance(1);
    chk("t1 ocioso k+25", 32'(dbEstado), 32'd0);
    chk("t1 queue empty", 32'(expQ.size()), 32'd0);

    // Rejected request
    pulse(4, 4);
    chk("t4 erro pulse", 32'(erroEntrada), 32'd1);
    chk("t4 no stop", 32'(paradaValida), 32'd0);
    chk("t4 ocioso", 32'(dbEstado), 32'd0);
    advance(1);
    chk("t4 erro one cycle", 32'(erroEntrada), 32'd0);
    chk("t4 still ocioso", 32'(dbEstado), 32'd0);
    chk("t4 still no stop", 32'(paradaValida), 32'd0);

    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1;
    advance(1);

    // Pickup on the way: 0->5 then 2->7
    expQ.push_back('{0, 1});
    expQ.push_back('{2, 1});
    expQ.push_back('{5, 1});
    expQ.push_back('{7, 1});
    pulse(0, 5);
    waitMove();
    pulse(2, 7);
    chk("t2 proxParada", 32'(proxParada), 32'd2);
    waitIdle("t2 idle");
    chk("t2 final floor", 32'(andarAtual), 32'd7);

    // Reverse: 3->1 from floor 7
    expQ.push_back('{3, 0});
    expQ.push_back('{1, 0});
    pulse(3, 1);
    chk("t3 proxParada", 32'(proxParada), 32'd3);
    advance(1);
    chk("t3 flipped", 32'(elevador_subindo), 32'd0);
    chk("t3 movendo", 32'(movendo), 32'd1);
    waitIdle("t3 idle");
    chk("t3 final floor", 32'(andarAtual), 32'd1);

    // Door restart at floor 2
    expQ.push_back('{1, 0});
    expQ.push_back('{2, 1});
    pulse(1, 2);
    for (int i = 0; i < 300 && !(portaAberta && andarAtual == 4'd2); i++) advance(1);
    chk("t5 door at 2", 32'(portaAberta && andarAtual == 4'd2), 32'd1);
    advance(2);
    expQ.push_back('{6, 1});
    pulse(2, 6);
    advance(5);
    chk("t5 door held", 32'(portaAberta), 32'd1);
    chk("t5 still at 2", 32'(andarAtual), 32'd2);
    advance(1);
    chk("t5 leaves", 32'(movendo), 32'd1);
    waitIdle("t5 idle");
    chk("t5 final floor", 32'(andarAtual), 32'd6);

    // Asynchronous reset mid-travel
    expQ.push_back('{3, 0});
    pulse(3, 0);
    waitMove();
    advance(2);
    #2;
    reset = 1'b0;
    expQ.delete();
    #1;
    chkReset("async reset");
    @(negedge clock); reset = 1'b1;
    advance(10);
    chk("post reset ocioso", 32'(dbEstado), 32'd0);
    chk("post reset floor", 32'(andarAtual), 32'd0);
    chk("post reset no stop", 32'(paradaValida), 32'd0);
    chk("post reset no doors", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
